// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration-write scheduler: register map,
// frame layout, FSM state encodings and small frame helpers.
package spi_cfg_pkg;

    localparam logic [6:0] MAX_ADDRESS      = 7'd4;
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'd3;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'd4;

    localparam int   FRAME_W   = 16;
    localparam logic WRITE_BIT = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_SCLK_HI = 3'd2;
    localparam state_t ST_SCLK_LO = 3'd3;
    localparam state_t ST_HOLD    = 3'd4;
    localparam state_t ST_GAP     = 3'd5;

    // Write frame as shifted out, MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                       input logic [7:0] data);
        return {WRITE_BIT, addr, data};
    endfunction

    // Only addresses inside the peripheral's register map produce a frame.
    function automatic logic addr_is_valid(input logic [6:0] addr);
        return (addr <= MAX_ADDRESS);
    endfunction

endpackage

// File: rtl/spi_cfg_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester,
// pointer moves only when the grant is actually taken (advance_i).
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             any_o
);

    logic [IW-1:0]    last_q;
    logic [IW-1:0]    last_d;
    logic [IW-1:0]    idx_s;
    logic [N_REQ-1:0] grant_s;
    logic             found_s;

    // Pick the first requesting index after the last grant, wrapping around.
    always_comb begin
        grant_s = {N_REQ{1'b0}};
        idx_s   = last_q;
        found_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int cand;
            cand = int'(last_q) + 1 + k;
            cand = (cand >= N_REQ) ? cand - N_REQ : cand;
            if (!found_s && req_i[cand[IW-1:0]]) begin
                grant_s[cand[IW-1:0]] = 1'b1;
                idx_s                 = cand[IW-1:0];
                found_s               = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer value: the granted index when the grant is consumed.
    always_comb begin
        if (advance_i) begin
            last_d = idx_s;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset points at the highest index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

    assign grant_o = grant_s;
    assign any_o   = found_s;

endmodule

// File: rtl/spi_cfg_write_scheduler.sv
// Arbitrates register-write requests and serialises each accepted one as a
// 16-bit mode-0 SPI frame, with a fixed nCS-high gap between frames so the
// peripheral's synchronisers always see clean edges.
module spi_cfg_write_scheduler
    import spi_cfg_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               nCS,
    output logic               SCLK,
    output logic               COPI,
    output logic               busy,
    output logic               done,
    output logic               err_addr
);

    localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int PH_W    = $clog2(CNT_MAX + 1);
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [PH_W-1:0] HP_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYCLES - 1);
    localparam logic [4:0]      LAST_BIT = 5'd16;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic                ncs_q, ncs_d;
    logic                sclk_q, sclk_d;
    logic                copi_q, copi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [N_REQ-1:0]    grant_s;
    logic                any_s;
    logic                accept_s;
    logic [6:0]          sel_addr_s;
    logic [7:0]          sel_data_s;
    logic                hp_end_s;
    logic                frame_active_s;

    assign accept_s = (state_q == ST_IDLE) && any_s;
    assign hp_end_s = (phase_q == HP_LAST);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .advance_i (accept_s),
        .grant_o   (grant_s),
        .any_o     (any_s)
    );

    // Grant is visible only in IDLE and never while reset is asserted.
    always_comb begin
        if (rst_n && accept_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel_addr_s = 7'd0;
        sel_data_s = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr_s = sel_addr_s | (req_addr[i*7 +: 7] & {7{grant_s[i]}});
            sel_data_s = sel_data_s | (req_data[i*8 +: 8] & {8{grant_s[i]}});
        end
    end

    // Frame sequencing: every SPI phase lasts HALF_PERIOD cycles, the gap GAP_CYCLES.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = {PH_W{1'b0}};
                if (accept_s && addr_is_valid(sel_addr_s)) begin
                    shift_d   = build_frame(sel_addr_s, sel_data_s);
                    bit_cnt_d = 5'd0;
                    state_d   = ST_SETUP;
                end else if (accept_s) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP, ST_SCLK_LO: begin
                if (hp_end_s) begin
                    phase_d   = {PH_W{1'b0}};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = ST_SCLK_HI;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_SCLK_HI: begin
                if (hp_end_s && (bit_cnt_q == LAST_BIT)) begin
                    phase_d = {PH_W{1'b0}};
                    state_d = ST_HOLD;
                end else if (hp_end_s) begin
                    phase_d = {PH_W{1'b0}};
                    shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    state_d = ST_SCLK_LO;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (hp_end_s) begin
                    phase_d = {PH_W{1'b0}};
                    state_d = ST_GAP;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_q == GAP_LAST) begin
                    phase_d = {PH_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                phase_d = {PH_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values follow the next state so they change on the same edge as the FSM.
    always_comb begin
        frame_active_s = (state_d == ST_SETUP) || (state_d == ST_SCLK_HI) ||
                         (state_d == ST_SCLK_LO) || (state_d == ST_HOLD);
        ncs_d  = !frame_active_s;
        sclk_d = (state_d == ST_SCLK_HI);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_GAP) && (state_q != ST_GAP);
        if (frame_active_s) begin
            copi_d = shift_d[FRAME_W-1];
        end else begin
            copi_d = 1'b0;
        end
    end

    // State and pin registers; reset drops any partial frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= {PH_W{1'b0}};
            bit_cnt_q <= 5'd0;
            shift_q   <= {FRAME_W{1'b0}};
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ncs_q     <= ncs_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign nCS      = ncs_q;
    assign SCLK     = sclk_q;
    assign COPI     = copi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_addr = err_q;

endmodule
